// File: rtl/mlu_pipe.sv
// Fully pipelined integer multiplier: input register, log2(WIDTH) adder-tree levels, output register.
// Supports unsigned, signed x signed and signed x unsigned modes, with a sideband tag, global stall and flush.
module mlu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [WIDTH-1:0]       in_op1,
    input  logic [WIDTH-1:0]       in_op2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_result,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int L     = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam int NODES = WIDTH - 1;

    // Handshake: a transfer happens on an edge where valid && ready; the whole
    // pipe stalls only while a result is held un-accepted at the output.
    logic stall;

    logic             out_valid_q;
    logic [PW-1:0]    out_result_q;
    logic [TAG_W-1:0] out_tag_q;

    logic [L:0]       vld_q;
    logic [L:0]       neg_q;
    logic [TAG_W-1:0] tag_q [L+1];

    logic [WIDTH-1:0] mag1_d, mag2_d, mag1_q, mag2_q;
    logic             neg_d;
    logic             op1_signed, op2_signed;

    logic [PW-1:0]    pp     [WIDTH];
    logic [PW-1:0]    node_d [NODES];
    logic [PW-1:0]    node_q [NODES];
    logic [PW-1:0]    res_d;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

    assign op1_signed = (in_mode == 2'b01) || (in_mode == 2'b10);
    assign op2_signed = (in_mode == 2'b01);

    always_comb begin
        mag1_d = (op1_signed && in_op1[WIDTH-1]) ? -in_op1 : in_op1;
        mag2_d = (op2_signed && in_op2[WIDTH-1]) ? -in_op2 : in_op2;
        neg_d  = (op1_signed && in_op1[WIDTH-1]) ^ (op2_signed && in_op2[WIDTH-1]);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = mag2_q[i] ? {{WIDTH{1'b0}}, mag1_q} : '0;
        end
    end

    // Tree levels are packed back to back in node_q: level k starts at lvl_off(k)
    // and holds WIDTH >> k sums; the single root sits in the last slot.
    function automatic int lvl_off(input int k);
        return WIDTH - (WIDTH >> (k - 1));
    endfunction

    always_comb begin
        node_d = node_q;
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < (WIDTH >> k); j++) begin
                if (k == 1) begin
                    node_d[j] = pp[2*j] + (pp[2*j+1] << 1);
                end else begin
                    node_d[lvl_off(k)+j] = node_q[lvl_off(k-1)+2*j]
                                         + (node_q[lvl_off(k-1)+2*j+1] << (1 << (k - 1)));
                end
            end
        end
    end

    assign res_d = neg_q[L] ? -node_q[NODES-1] : node_q[NODES-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (flush) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            vld_q        <= {vld_q[L-1:0], in_valid};
            out_valid_q  <= vld_q[L];
            out_result_q <= res_d;
            out_tag_q    <= tag_q[L];
        end
    end

    // Datapath registers carry no reset; validity is tracked by vld_q alone.
    always_ff @(posedge clk) begin
        if (!stall) begin
            mag1_q   <= mag1_d;
            mag2_q   <= mag2_d;
            neg_q    <= {neg_q[L-1:0], neg_d};
            tag_q[0] <= in_tag;
            for (int k = 1; k <= L; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            node_q <= node_d;
        end
    end

endmodule

// File: doc/mlu_pipe.md
# mlu_pipe

Parametrised, fully pipelined integer multiplier that supersedes the fixed 32-bit state-sequenced MLU. It accepts one operand pair per cycle under a valid/ready handshake and supports unsigned, signed×signed and signed×unsigned modes. It carries a caller tag to the result and supports whole-pipeline backpressure and flush. It sits in the execute stage, feeding the writeback mux for MUL/MULH/MULHSU/MULHU.

## Interface
- WIDTH, 32: operand width; power of two, 4..64.
- TAG_W, 5: width of the sideband tag, e.g. destination register index.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pipeline can accept this cycle.
- in_mode  in  2  00 unsigned×unsigned, 01 signed×signed, 10 signed(op1)×unsigned(op2), 11 treated as 00.
- in_op1  in  WIDTH  multiplicand.
- in_op2  in  WIDTH  multiplier.
- in_tag  in  TAG_W  returned with result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  2*WIDTH  full product, two's complement when a signed mode is used.
- out_tag  out  TAG_W  tag of the operation producing out_result.

## Operation
- Accept when in_valid && in_ready && !flush.
- Stage 0 (input register):
  - Convert each operand to magnitude: op1 negated if mode∈{01,10} and op1 MSB=1; op2 negated if mode=01 and op2 MSB=1.
  - Latch neg = sign(op1) XOR sign(op2) under the same rules.
  - Generate WIDTH partial products, pp[i] = op2mag[i] ? op1mag : 0.
  - Magnitudes are WIDTH-bit unsigned; the most negative operand (e.g. 0x80000000) has magnitude 2^(WIDTH-1), which fits.
- Stages 1..L, L = log2(WIDTH):
  - Binary adder tree; level k sums adjacent pairs with the upper term shifted left by 2^(k-1).
  - Each level widens by 2^(k-1)+1 bits, truncated to 2*WIDTH.
- Final stage: out_result = neg ? two's complement of the sum : sum, over 2*WIDTH bits.
- Every stage carries valid, neg and tag alongside its data.
- Backpressure is global: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register holds, including out_result, out_tag and out_valid.
  - Bubbles are not compressed.
- Flush takes priority over all other activity:
  - On the cycle flush=1, all stage valids and out_valid clear on the next edge, regardless of stall.
  - An input presented in the same cycle is dropped.
  - Data registers need not clear.
- Reset (resetn=0 at an edge): all valids and out_valid become 0, and out_result=0 and out_tag=0.
  - Reset mid-operation discards all in-flight work.
  - in_ready is 1 from the first cycle after reset.

## Timing
- Latency LAT = log2(WIDTH)+2 cycles: 7 for WIDTH=32, 5 for WIDTH=8.
  - An operation accepted at edge N appears with out_valid=1 after edge N+LAT-1, i.e. it is visible during cycle N+LAT when no stall occurs.
- Throughput is one result per cycle with out_ready held high.
- Each stall cycle adds exactly one cycle to the latency of every in-flight operation.
- in_ready is combinational from out_valid/out_ready, with no other combinational path input→output.
- Results leave in acceptance order; tags never reorder.
- out_result/out_tag are stable whenever out_valid=1 && out_ready=0.

## Test plan
- Modes, WIDTH=32:
  - op1=op2=0xFFFFFFFF, mode 00 → 0xFFFFFFFE_00000001.
  - Same operands, mode 01 → 0x00000000_00000001.
  - Same operands, mode 10 → 0xFFFFFFFF_00000001.
- Corners, mode 01: 0x80000000×0x80000000 → 0x40000000_00000000; 0x80000000×0x00000001 → 0xFFFFFFFF_80000000; 0×0x12345678 → 0.
- Streaming: 100 random back-to-back ops (all modes, tag=index) with out_ready=1 → first out_valid 7 cycles after the first accept, then one result per cycle, in order; matches the reference model with tags 0..99.
- Backpressure: random out_ready (50%) → no result lost or duplicated, outputs stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Flush/reset: fill 5 ops, assert flush for one cycle concurrent with in_valid → no out_valid for those 6, and the next accepted op returns after 7 cycles. Repeat with resetn=0 mid-stream → out_valid=0, out_result=0, out_tag=0 after the reset edge.
- Parameter: WIDTH=8, TAG_W=3, exhaustive 65536 pairs × 3 modes → all products correct, latency 5.
